core_mem_arbiter: RTL

//  Shares one backing-memory port between the Core's icache and dcache request channels.

---
 rtl/core_mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - icache/dcache arbiter for one shared backing-memory port
module core_mem_arbiter #(
   parameter int XLEN     = 32,
   parameter int D_STREAK = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            io_icache_req_valid,
   input  logic [XLEN-1:0] io_icache_req_bits_addr,
   output logic            io_icache_resp_valid,
   output logic [XLEN-1:0] io_icache_resp_bits_data,
   input  logic            io_dcache_abort,
   input  logic            io_dcache_req_valid,
   input  logic [XLEN-1:0] io_dcache_req_bits_addr,
   input  logic [XLEN-1:0] io_dcache_req_bits_data,
   input  logic [3:0]      io_dcache_req_bits_mask,
   output logic            io_dcache_resp_valid,
   output logic [XLEN-1:0] io_dcache_resp_bits_data,
   output logic            io_mem_req_valid,
   input  logic            io_mem_req_ready,
   output logic [XLEN-1:0] io_mem_req_bits_addr,
   output logic [XLEN-1:0] io_mem_req_bits_data,
   output logic [3:0]      io_mem_req_bits_mask,
   input  logic            io_mem_resp_valid,
   input  logic [XLEN-1:0] io_mem_resp_bits_data
);

   localparam int SW = (D_STREAK < 1) ? 1 : $clog2(D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK);

   typedef enum logic [2:0] {
      S_IDLE,
      S_D_STAGE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [SW-1:0]   streak;
   logic            owner_d;
   logic [XLEN-1:0] txn_addr;
   logic [XLEN-1:0] txn_data;
   logic [3:0]      txn_mask;
   logic [XLEN-1:0] resp_data;
   logic            d_win;

   // dcache wins unless icache is waiting and dcache has used up its streak
   assign d_win = io_dcache_req_valid &&
                  (!io_icache_req_valid || (streak < STREAK_MAX));

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and outputs; buses are forced to 0 outside their active state
   always_comb begin
      state_nxt                = state;
      io_mem_req_valid         = 1'b0;
      io_mem_req_bits_addr     = '0;
      io_mem_req_bits_data     = '0;
      io_mem_req_bits_mask     = 4'h0;
      io_icache_resp_valid     = 1'b0;
      io_icache_resp_bits_data = '0;
      io_dcache_resp_valid     = 1'b0;
      io_dcache_resp_bits_data = '0;
      case (state)
         S_IDLE: begin
            if (d_win) begin
               state_nxt = S_D_STAGE;
            end else if (io_icache_req_valid) begin
               state_nxt = S_ISSUE;
            end
         end
         S_D_STAGE: begin
            state_nxt = io_dcache_abort ? S_IDLE : S_ISSUE;
         end
         S_ISSUE: begin
            io_mem_req_valid     = 1'b1;
            io_mem_req_bits_addr = txn_addr;
            io_mem_req_bits_data = txn_data;
            io_mem_req_bits_mask = txn_mask;
            if (io_mem_req_ready) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (io_mem_resp_valid) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (owner_d) begin
               io_dcache_resp_valid     = 1'b1;
               io_dcache_resp_bits_data = resp_data;
            end else begin
               io_icache_resp_valid     = 1'b1;
               io_icache_resp_bits_data = resp_data;
            end
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // transaction latch at grant, streak bookkeeping, response capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         streak    <= '0;
         owner_d   <= 1'b0;
         txn_addr  <= '0;
         txn_data  <= '0;
         txn_mask  <= 4'h0;
         resp_data <= '0;
      end else begin
         if (state == S_IDLE) begin
            if (d_win) begin
               owner_d  <= 1'b1;
               txn_addr <= io_dcache_req_bits_addr;
               txn_data <= io_dcache_req_bits_data;
               txn_mask <= io_dcache_req_bits_mask;
               if (io_icache_req_valid) begin
                  streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
               end else begin
                  streak <= '0;
               end
            end else if (io_icache_req_valid) begin
               owner_d  <= 1'b0;
               txn_addr <= io_icache_req_bits_addr;
               txn_data <= '0;
               txn_mask <= 4'h0;
               streak   <= '0;
            end
         end
         // stores acknowledge with zero data; loads pass memory data through untouched
         if ((state == S_WAIT) && io_mem_resp_valid) begin
            resp_data <= (txn_mask != 4'h0) ? '0 : io_mem_resp_bits_data;
         end
      end
   end

endmodule
